// File: rtl/vip_dehaze_pkg.sv
`default_nettype none
// ============================================================================
// Module : vip_dehaze_pkg
// Brief  : Shared widths, FSM state type and helpers for the dehaze pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
package vip_dehaze_pkg;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // One extra bit so (cand - A) is representable as a signed value.
    typedef logic signed [PIX_W:0] iir_t;

    function automatic logic [PIX_W-1:0] max3(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b,
        input logic [PIX_W-1:0] c
    );
        logic [PIX_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vip_frame_pos_counter.sv
`default_nettype none
// ============================================================================
// Module : vip_frame_pos_counter
// Brief  : Pixel x/y position, frame-start detect and frame geometry check.
// Rev    : 1.0 - initial release
// ============================================================================
module vip_frame_pos_counter
    import vip_dehaze_pkg::*;
#(
    parameter logic [COORD_W-1:0] IMG_HDISP = 11'd800,
    parameter logic [COORD_W-1:0] IMG_VDISP = 11'd600
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               href,
    input  logic               clken,
    output logic               pix,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start,
    output logic               geom_err
);

    logic               vsync_q;
    logic               href_q;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               line_err_q, line_err_d;
    logic               href_fall;
    logic               line_err_now;

    always_comb begin
        pix          = href & clken;
        href_fall    = href_q & ~href;
        frame_start  = vsync & ~vsync_q;
        line_err_now = href_fall && (x_q != IMG_HDISP);
        x_d          = x_q;
        y_d          = y_q;
        line_err_d   = line_err_q;
        if (frame_start) begin
            x_d        = '0;
            y_d        = '0;
            line_err_d = 1'b0;
        end else if (href_fall) begin
            x_d = '0;
            y_d = y_q + 11'd1;
            if (line_err_now) begin
                line_err_d = 1'b1;
            end
        end else if (pix) begin
            x_d = x_q + 11'd1;
        end
        // Valid only in the frame_start cycle; covers a bad line ending right now.
        geom_err = line_err_q | line_err_now | (y_q != IMG_VDISP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            line_err_q <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            x_q        <= x_d;
            y_q        <= y_d;
            line_err_q <= line_err_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule
`default_nettype wire

// File: rtl/vip_atmos_light_est.sv
`default_nettype none
// ============================================================================
// Module : vip_atmos_light_est
// Brief  : Per-frame atmospheric light estimate from the dark channel peak,
//          IIR-smoothed across frames and clamped; dark stream passed through.
// Rev    : 1.0 - initial release
// ============================================================================
module vip_atmos_light_est
    import vip_dehaze_pkg::*;
#(
    parameter logic [COORD_W-1:0] IMG_HDISP = 11'd800,
    parameter logic [COORD_W-1:0] IMG_VDISP = 11'd600,
    parameter logic [PIX_W-1:0]   A_INIT    = 8'd255,
    parameter logic [PIX_W-1:0]   A_MIN     = 8'd100,
    parameter int                 IIR_SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         per_frame_vsync,
    input  logic         per_frame_href,
    input  logic         per_frame_clken,
    input  logic [7:0]   per_img_dark,
    input  logic [7:0]   per_img_red,
    input  logic [7:0]   per_img_green,
    input  logic [7:0]   per_img_blue,
    output logic         post_frame_vsync,
    output logic         post_frame_href,
    output logic         post_frame_clken,
    output logic [7:0]   post_img_dark,
    output logic [7:0]   atmospheric_light,
    output logic [10:0]  atmospheric_pos_x,
    output logic [10:0]  atmospheric_pos_y,
    output logic         light_valid,
    output logic         frame_err
);

    logic               pix;
    logic               frame_start;
    logic               geom_err;
    logic [COORD_W-1:0] x, y;

    vip_frame_pos_counter #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (per_frame_vsync),
        .href        (per_frame_href),
        .clken       (per_frame_clken),
        .pix         (pix),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .geom_err    (geom_err)
    );

    state_t             state_q, state_d;
    logic               first_frame_q, first_frame_d;
    logic [PIX_W-1:0]   cur_max_q, cur_max_d;
    logic [PIX_W-1:0]   cand_q, cand_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic               err_pend_q, err_pend_d;
    logic [PIX_W-1:0]   a_q, a_d;
    logic [COORD_W-1:0] a_pos_x_q, a_pos_x_d;
    logic [COORD_W-1:0] a_pos_y_q, a_pos_y_d;
    logic               light_valid_q, light_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               pt_vsync_q, pt_vsync_d;
    logic               pt_href_q, pt_href_d;
    logic               pt_clken_q, pt_clken_d;
    logic [PIX_W-1:0]   pt_dark_q, pt_dark_d;

    logic [PIX_W-1:0]   rgb_max;
    iir_t               iir_diff;
    iir_t               iir_sum;
    logic [PIX_W-1:0]   a_raw;
    logic [PIX_W-1:0]   a_pub;
    logic               load;
    logic               clear;

    always_comb begin
        pt_vsync_d    = per_frame_vsync;
        pt_href_d     = per_frame_href;
        pt_clken_d    = per_frame_clken;
        pt_dark_d     = per_img_dark;

        state_d       = state_q;
        first_frame_d = first_frame_q;
        cur_max_d     = cur_max_q;
        cand_d        = cand_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        err_pend_d    = err_pend_q;
        a_d           = a_q;
        a_pos_x_d     = a_pos_x_q;
        a_pos_y_d     = a_pos_y_q;
        frame_err_d   = frame_err_q;
        light_valid_d = 1'b0;
        load          = 1'b0;
        clear         = 1'b0;

        rgb_max  = max3(per_img_red, per_img_green, per_img_blue);
        iir_diff = $signed({1'b0, cand_q}) - $signed({1'b0, a_q});
        iir_sum  = $signed({1'b0, a_q}) + (iir_diff >>> IIR_SHIFT);
        if (first_frame_q) begin
            a_raw = cand_q;
        end else begin
            a_raw = iir_sum[PIX_W] ? '0 : iir_sum[PIX_W-1:0];
        end
        a_pub = (a_raw < A_MIN) ? A_MIN : a_raw;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = ACCUM;
                    clear   = 1'b1;
                end
            end
            ACCUM: begin
                if (frame_start) begin
                    state_d    = UPDATE;
                    err_pend_d = geom_err;
                end else if (pix && (per_img_dark > cur_max_q)) begin
                    load = 1'b1;
                end
            end
            UPDATE: begin
                state_d = ACCUM;
                clear   = 1'b1;
                // First pixel of the new frame competes against the cleared max of 0.
                load    = pix && (per_img_dark != '0);
                if (err_pend_q) begin
                    frame_err_d = 1'b1;
                end else begin
                    a_d           = a_pub;
                    a_pos_x_d     = pos_x_q;
                    a_pos_y_d     = pos_y_q;
                    light_valid_d = 1'b1;
                    frame_err_d   = 1'b0;
                    first_frame_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            cur_max_d = '0;
            cand_d    = '0;
            pos_x_d   = '0;
            pos_y_d   = '0;
        end
        if (load) begin
            cur_max_d = per_img_dark;
            cand_d    = rgb_max;
            pos_x_d   = x;
            pos_y_d   = y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            first_frame_q <= 1'b1;
            cur_max_q     <= '0;
            cand_q        <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            err_pend_q    <= 1'b0;
            a_q           <= A_INIT;
            a_pos_x_q     <= '0;
            a_pos_y_q     <= '0;
            light_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            pt_vsync_q    <= 1'b0;
            pt_href_q     <= 1'b0;
            pt_clken_q    <= 1'b0;
            pt_dark_q     <= '0;
        end else begin
            state_q       <= state_d;
            first_frame_q <= first_frame_d;
            cur_max_q     <= cur_max_d;
            cand_q        <= cand_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            err_pend_q    <= err_pend_d;
            a_q           <= a_d;
            a_pos_x_q     <= a_pos_x_d;
            a_pos_y_q     <= a_pos_y_d;
            light_valid_q <= light_valid_d;
            frame_err_q   <= frame_err_d;
            pt_vsync_q    <= pt_vsync_d;
            pt_href_q     <= pt_href_d;
            pt_clken_q    <= pt_clken_d;
            pt_dark_q     <= pt_dark_d;
        end
    end

    assign post_frame_vsync  = pt_vsync_q;
    assign post_frame_href   = pt_href_q;
    assign post_frame_clken  = pt_clken_q;
    assign post_img_dark     = pt_dark_q;
    assign atmospheric_light = a_q;
    assign atmospheric_pos_x = a_pos_x_q;
    assign atmospheric_pos_y = a_pos_y_q;
    assign light_valid       = light_valid_q;
    assign frame_err         = frame_err_q;

endmodule
`default_nettype wire
